// File: rtl/bcd_scan_display.sv
// 3-digit time-multiplexed common-anode 7-segment driver with frame-synchronous digit commit.
// Optional leading-zero blanking is compiled in when BLANK_LZ_EN is defined.
module bcd_scan_display #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    SCAN_ONES = 2'd0,
    SCAN_TENS = 2'd1,
    SCAN_HUND = 2'd2
  } scan_e;

  scan_e         state;
  scan_e         state_nx;
  logic [PW-1:0] presc;
  logic          tick;
  logic          wrap;
  logic          capture;

  logic          pending;
  logic [3:0]    hold_ones;
  logic [3:0]    hold_tens;
  logic [3:0]    hold_hund;
  logic [3:0]    shown_ones;
  logic [3:0]    shown_tens;
  logic [3:0]    shown_hund;

  logic [3:0]    cur_digit;
  logic [2:0]    cur_an;
  logic          cur_lit;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h3F;
    endcase
    return code;
  endfunction

  assign tick     = (presc == PRESC_MAX);
  assign wrap     = tick && (state == SCAN_HUND);
  assign in_ready = !pending && !rst;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN_ONES;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (tick) begin
      case (state)
        SCAN_ONES: state_nx = SCAN_TENS;
        SCAN_TENS: state_nx = SCAN_HUND;
        default:   state_nx = SCAN_ONES;
      endcase
    end
  end

  always_comb begin
    cur_digit = shown_ones;
    cur_an    = 3'b110;
    cur_lit   = 1'b1;
    case (state)
      SCAN_TENS: begin
        cur_digit = shown_tens;
        cur_an    = 3'b101;
`ifdef BLANK_LZ_EN
        cur_lit   = !((shown_hund == 4'd0) && (shown_tens == 4'd0));
`endif
      end
      SCAN_HUND: begin
        cur_digit = shown_hund;
        cur_an    = 3'b011;
`ifdef BLANK_LZ_EN
        cur_lit   = (shown_hund != 4'd0);
`endif
      end
      default: begin
        cur_digit = shown_ones;
        cur_an    = 3'b110;
      end
    endcase
  end

  // Commit only at the frame wrap so every frame shows one consistent value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      hold_ones  <= '0;
      hold_tens  <= '0;
      hold_hund  <= '0;
      shown_ones <= '0;
      shown_tens <= '0;
      shown_hund <= '0;
    end else if (wrap && pending) begin
      pending    <= 1'b0;
      shown_ones <= hold_ones;
      shown_tens <= hold_tens;
      shown_hund <= hold_hund;
    end else if (capture) begin
      pending    <= 1'b1;
      hold_ones  <= ones;
      hold_tens  <= tens;
      hold_hund  <= hundreds;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 3'b111;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      an         <= cur_lit ? cur_an : 3'b111;
      seg        <= cur_lit ? seg_code(cur_digit) : 7'h7F;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: a time-based reference model queues per-cycle expectations,
// a monitor compares them against the DUT; honours BLANK_LZ_EN like the design.
module tb_bcd_scan_display;
  localparam int DIV   = 4;
  localparam int FRAME = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ones = '0;
  logic [3:0] tens = '0;
  logic [3:0] hundreds = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] an;
  logic [6:0] seg;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] code_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model state: t counts cycles since reset release; the lit slot follows from t alone.
  int         t = 0;
  bit         pend = 0;
  int         hold[3];
  int         shown[3];
  logic [2:0] m_an = 3'b111;
  logic [6:0] m_seg = 7'h7F;
  bit         m_fd = 0;
  bit         known = 0;
  bit         in_rst = 0;

  function automatic bit slot_lit(int slot);
`ifdef BLANK_LZ_EN
    if (slot == 2) return shown[2] != 0;
    if (slot == 1) return !(shown[2] == 0 && shown[1] == 0);
`endif
    return slot >= 0;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input bit v, input int o, input int tn, input int h, input bit r);
    exp_t e;
    int   slot;
    rst      = r;
    in_valid = v;
    ones     = 4'(o);
    tens     = 4'(tn);
    hundreds = 4'(h);
    if (known && (!r || in_rst)) begin
      e.an  = m_an;
      e.seg = m_seg;
      e.fd  = m_fd;
      e.rdy = !r && !pend;
      sb.push_back(e);
    end
    if (r) begin
      t = 0; pend = 0; shown = '{0, 0, 0};
      m_an = 3'b111; m_seg = 7'h7F; m_fd = 0;
      in_rst = 1; known = 1;
    end else begin
      slot = (t / DIV) % 3;
      if (slot_lit(slot)) begin
        m_an  = ~(3'b001 << slot);
        m_seg = code_tab[shown[slot]];
      end else begin
        m_an  = 3'b111;
        m_seg = 7'h7F;
      end
      m_fd = (t % FRAME) == FRAME - 1;
      if (m_fd && pend) begin
        shown = hold;
        pend  = 0;
      end else if (v && !pend) begin
        hold = '{o, tn, h};
        pend = 1;
      end
      t++;
      in_rst = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("an", {4'b0, an}, {4'b0, got.an});
        chk("seg", seg, got.seg);
        chk("frame_done", {6'b0, frame_done}, {6'b0, got.fd});
        chk("in_ready", {6'b0, in_ready}, {6'b0, got.rdy});
      end
    end
  end

  initial begin
    int o, tn, h;
    bit r, v;
    repeat (3) step(0, 0, 0, 0, 1);
    idle(3 * FRAME);

    // 255 captured mid-frame
    wait_phase(3);
    step(1, 5, 5, 2, 0);
    idle(2 * FRAME);

    // backpressure: 123 held while pending, then 999 before the commit
    wait_phase(2);
    for (int i = 0; i < 4; i++) step(1, 1, 2, 3, 0);
    for (int i = 0; i < FRAME; i++) step(1, 9, 9, 9, 0);
    step(0, 0, 0, 0, 0);
    idle(2 * FRAME);

    // invalid ones code
    wait_phase(5);
    step(1, 12, 3, 1, 0);
    idle(2 * FRAME);

    // reset one cycle before the wrap discards the capture
    wait_phase(4);
    step(1, 7, 0, 0, 0);
    wait_phase(FRAME - 2);
    step(0, 0, 0, 0, 1);
    idle(2 * FRAME);

    // value 7: zero blanking or zeros lit, depending on the build
    step(1, 7, 0, 0, 0);
    idle(2 * FRAME);

    // capture on the wrap-tick cycle itself waits for the next wrap
    wait_phase(FRAME - 1);
    step(1, 8, 6, 0, 0);
    idle(2 * FRAME);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 5) == 0);
      o  = $urandom_range(0, 15);
      tn = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      h  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15);
      step(v, o, tn, h, r);
    end
    idle(2 * FRAME);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    chk("scoreboard_drained", 7'(sb.size()), 7'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
